// File: rtl/tree_feat_pkg.sv
// tree_feat_pkg: shared constants, FSM state and feature-vector type for tree_feature_loader
package tree_feat_pkg;
    localparam int N_FEAT_DEF = 51;
    localparam int NB_BYTES = (N_FEAT_DEF + 7) / 8;
    typedef enum logic [1:0] {LOAD, DRAIN, SETTLE, OUT} state_t;
    typedef logic [N_FEAT_DEF-1:0] feat_vec_t;
endpackage

// File: rtl/tree_feature_loader_if.sv
// tree_feature_loader_if: byte stream in (s_valid/s_ready/s_data/s_last) and result out (m_valid/m_ready/m_class/m_err); slave = loader, master = host
interface tree_feature_loader_if #(parameter int N_OUT = 1);
    logic s_valid, s_ready, s_last, m_valid, m_ready, m_err;
    logic [7:0] s_data;
    logic [N_OUT-1:0] m_class;
    modport slave(input s_valid, s_data, s_last, m_ready, output s_ready, m_valid, m_class, m_err);
    modport master(output s_valid, s_data, s_last, m_ready, input s_ready, m_valid, m_class, m_err);
endinterface

// File: rtl/tree_feat_shreg.sv
// tree_feat_shreg: byte-slot writer holding feat_o; ports clk, rst_n, we/idx/data (write slot idx), zf (also clear slots above idx), feat_o
module tree_feat_shreg #(
    parameter int N_FEAT = 51,
    parameter int IW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              zf,
    input  logic [IW-1:0]     idx,
    input  logic [7:0]        data,
    output logic [N_FEAT-1:0] feat_o
);
    // Only N_FEAT bits are stored; bits of the last byte above N_FEAT-1 have no flop.
    for (genvar i = 0; i < N_FEAT; i++) begin : g_bit
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) feat_o[i] <= 1'b0;
            else if (we && idx == IW'(i / 8)) feat_o[i] <= data[i % 8];
            else if (we && zf && idx < IW'(i / 8)) feat_o[i] <= 1'b0;
    end
endmodule

// File: rtl/tree_feature_loader.sv
// tree_feature_loader: assembles a byte frame into feat_o, samples class_i after SETTLE_CYCLES, returns it on the result channel
// Ports: clk, rst_n (async, active low), bus (slave: byte stream + result channel), feat_o (to classifier), class_i (from classifier)
// Option: FEATURE_PARITY_EN adds a trailing XOR byte per frame; a mismatch sets m_err
module tree_feature_loader
    import tree_feat_pkg::*;
#(
    parameter int N_FEAT = N_FEAT_DEF,
    parameter int N_OUT = 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    tree_feature_loader_if.slave      bus,
    output logic [N_FEAT-1:0]         feat_o,
    input  logic [N_OUT-1:0]          class_i
);
    localparam int NB = (N_FEAT + 7) / 8;
`ifdef FEATURE_PARITY_EN
    localparam int FL = NB + 1;
`else
    localparam int FL = NB;
`endif
    localparam int CW = $clog2(FL + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] sc, sc_n;
    logic [N_OUT-1:0] cls, cls_n;
    logic err, err_n, merr, merr_n, xfer, fin, we, bad;
    // rst_n gates s_ready so no byte is offered as accepted while reset is held.
    assign bus.s_ready = rst_n && (state == LOAD || state == DRAIN);
    assign bus.m_valid = state == OUT;
    assign bus.m_class = cls;
    assign bus.m_err = merr;
    assign xfer = bus.s_valid && bus.s_ready;
    assign fin = cnt == CW'(FL - 1);
    assign we = state == LOAD && xfer && cnt < CW'(NB);
`ifdef FEATURE_PARITY_EN
    logic [7:0] par;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) par <= '0;
        else if (bus.m_valid && bus.m_ready) par <= '0;
        else if (we) par <= par ^ bus.s_data;
    assign bad = cnt == CW'(NB) && bus.s_data != par;
`else
    assign bad = 1'b0;
`endif
    tree_feat_shreg #(.N_FEAT(N_FEAT), .IW(CW)) u_shreg (
        .clk(clk), .rst_n(rst_n), .we(we), .zf(bus.s_last), .idx(cnt), .data(bus.s_data), .feat_o(feat_o)
    );
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        err_n = err;
        sc_n = sc;
        cls_n = cls;
        merr_n = merr;
        // s_last != fin covers both an early s_last and a missing s_last on the final byte.
        if (state == LOAD && xfer) begin
            cnt_n = cnt + 1'b1;
            err_n = err | bad | (bus.s_last != fin);
            state_n = bus.s_last ? SETTLE : fin ? DRAIN : LOAD;
        end
        if (state == DRAIN && xfer && bus.s_last) state_n = SETTLE;
        if (state == SETTLE) begin
            sc_n = sc + 1'b1;
            if (sc == SW'(SETTLE_CYCLES - 1)) begin
                sc_n = '0;
                cls_n = class_i;
                merr_n = err;
                state_n = OUT;
            end
        end
        if (state == OUT && bus.m_ready) begin
            cnt_n = '0;
            err_n = 1'b0;
            state_n = LOAD;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= LOAD;
            cnt <= '0;
            err <= 1'b0;
            sc <= '0;
            cls <= '0;
            merr <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            err <= err_n;
            sc <= sc_n;
            cls <= cls_n;
            merr <= merr_n;
        end
endmodule

// File: tb/tb_tree_feature_loader.sv
// tb_tree_feature_loader: randomized and directed frames checked against a frame-level reference model
module tb_tree_feature_loader;
    import tree_feat_pkg::*;
    localparam int NB = NB_BYTES;
`ifdef FEATURE_PARITY_EN
    localparam int FL = NB + 1;
`else
    localparam int FL = NB;
`endif
    localparam int SC = 1;
    typedef logic [7:0] bq_t[$];
    logic clk = 0;
    logic rst_n = 0;
    feat_vec_t feat_o;
    logic [0:0] class_i;
    int n_cmp = 0;
    int n_bad = 0;
    tree_feature_loader_if #(.N_OUT(1)) bus();
    tree_feature_loader #(.N_FEAT(N_FEAT_DEF), .N_OUT(1), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .feat_o(feat_o), .class_i(class_i)
    );
    always #5 clk = ~clk;
    assign class_i = ^feat_o;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bail(input string tag);
        chk(tag, 64'(0), 64'(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "aborted");
    endtask

    function automatic bq_t wp(input bq_t b);
        bq_t r = b;
`ifdef FEATURE_PARITY_EN
        logic [7:0] x = 8'h00;
        foreach (b[k]) x ^= b[k];
        r.push_back(x);
`endif
        return r;
    endfunction

    task automatic send(input bq_t b, input bit last);
        foreach (b[k]) begin
            while ($urandom_range(0, 3) == 0) begin
                bus.s_valid = 0;
                @(negedge clk);
            end
            bus.s_valid = 1;
            bus.s_data = b[k];
            bus.s_last = last && (k == b.size() - 1);
            if (k >= FL) chk("drain_rdy", 64'(bus.s_ready), 64'(1));
            for (int t = 0; !bus.s_ready; t++) begin
                if (t == 50) bail("s_ready_timeout");
                @(negedge clk);
            end
            @(negedge clk);
        end
        bus.s_valid = 0;
        bus.s_last = 0;
    endtask

    task automatic frame(input bq_t b, input int hold, input bit early);
        logic [NB*8-1:0] v;
        feat_vec_t ef;
        logic e;
        int n;
        v = '0;
        for (int k = 0; k < NB; k++) if (k < b.size()) v[8*k+:8] = b[k];
        ef = v[N_FEAT_DEF-1:0];
        e = b.size() != FL;
`ifdef FEATURE_PARITY_EN
        begin
            logic [7:0] x = 8'h00;
            for (int k = 0; k < NB && k < b.size(); k++) x ^= b[k];
            if (b.size() >= FL && b[NB] != x) e = 1;
        end
`endif
        bus.m_ready = early;
        send(b, 1);
        n = 0;
        while (!bus.m_valid) begin
            if (n == 20) bail("m_valid_timeout");
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(SC));
        chk("feat", 64'(feat_o), 64'(ef));
        chk("class", 64'(bus.m_class), 64'(^ef));
        chk("err", 64'(bus.m_err), 64'(e));
        if (!early) begin
            repeat (hold) begin
                @(negedge clk);
                chk("hold_valid", 64'(bus.m_valid), 64'(1));
                chk("hold_class", 64'(bus.m_class), 64'(^ef));
                chk("hold_err", 64'(bus.m_err), 64'(e));
                chk("hold_srdy", 64'(bus.s_ready), 64'(0));
            end
            bus.m_ready = 1;
        end
        @(negedge clk);
        bus.m_ready = 0;
        chk("post_valid", 64'(bus.m_valid), 64'(0));
        chk("post_srdy", 64'(bus.s_ready), 64'(1));
    endtask

    initial begin
        bq_t b;
        bus.s_valid = 0;
        bus.s_data = 0;
        bus.s_last = 0;
        bus.m_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_feat", 64'(feat_o), 64'(0));
        chk("rst_mvalid", 64'(bus.m_valid), 64'(0));
        chk("rst_mclass", 64'(bus.m_class), 64'(0));
        chk("rst_merr", 64'(bus.m_err), 64'(0));
        chk("rst_srdy", 64'(bus.s_ready), 64'(0));
        rst_n = 1;
        @(negedge clk);
        frame(wp('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}), 0, 1);
        chk("t1_feat", 64'(feat_o), 64'(51'h07060504030201));
        frame('{8'hAA, 8'hBB, 8'hCC}, 2, 0);
        chk("t2_feat", 64'(feat_o), 64'(51'h00000000CCBBAA));
        b = {};
        for (int k = 0; k < FL + 2; k++) b.push_back(8'(8'h10 + k));
        frame(b, 1, 0);
        frame(wp('{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'hFF}), 10, 0);
`ifdef FEATURE_PARITY_EN
        b = wp('{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE});
        frame(b, 0, 1);
        b[NB] = b[NB] ^ 8'h04;
        frame(b, 0, 1);
`endif
        send('{8'h21, 8'h22, 8'h23, 8'h24}, 0);
        rst_n = 0;
        #1;
        chk("mid_rst_feat", 64'(feat_o), 64'(0));
        chk("mid_rst_mvalid", 64'(bus.m_valid), 64'(0));
        chk("mid_rst_mclass", 64'(bus.m_class), 64'(0));
        chk("mid_rst_merr", 64'(bus.m_err), 64'(0));
        chk("mid_rst_srdy", 64'(bus.s_ready), 64'(0));
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        frame(wp('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37}), 0, 0);
        repeat (40) begin
            int len;
            len = $urandom_range(1, FL + 2);
            b = {};
            for (int k = 0; k < len && k < NB; k++) b.push_back(8'($urandom));
            if (len >= NB && $urandom_range(0, 3) != 0) b = wp(b);
            while (b.size() < len) b.push_back(8'($urandom));
            frame(b, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
